pmt_reg_cmd_arbiter: RTL

//  Shares the PMT master register-command link among NUM_REQ local requesters.

---
 rtl/pmt_reg_cmd_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/pmt_reg_cmd_arbiter.sv
// pmt_reg_cmd_arbiter
// Round-robin arbiter that shares the PMT master register-command link among
// NUM_REQ local requesters. Each grant becomes a two-word frame (header, data).
// Reads then wait for the link read-back word or a timeout, and the result is
// routed back to the requester that issued the read.
//
// Handshake on the frame port: a word is transferred on a clock edge where
// pmt_master_wr_vld[0] and pmt_master_wr_rdy are both 1. While rdy is 0 the
// word and vld are held stable. vld[1] marks the header word. req_ack[i]
// pulses in the same cycle that requester i's data word is transferred.
module pmt_reg_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic                  clk_100m,
    input  logic                  sys_rst_n,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ-1:0]    req_cmd,
    input  logic [16*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_vld,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [31:0]           pmt_master_wr_data,
    output logic [1:0]            pmt_master_wr_vld,
    input  logic                  pmt_master_wr_rdy,
    input  logic                  pmt_master_rd_vld,
    input  logic [31:0]           pmt_master_rd_data,
    output logic                  busy,
    output logic [2:0]            fsm_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(RD_TIMEOUT);

    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(RD_TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST     = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_REQ - 1);
    localparam logic [31:0]      TIMEOUT_WORD = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_DAT      = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic             cmd_q;
    logic [15:0]      addr_q;
    logic [31:0]      data_q;
    logic [TMR_W-1:0] timer_q;
    logic [7:0]       gap_cnt_q;

    logic [15:0]      addr_arr [NUM_REQ];
    logic [31:0]      data_arr [NUM_REQ];
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand_idx;
    int               arb_cand;

    logic [31:0]      hdr_word;
    logic             rd_timeout;
    logic             gap_done;

    assign hdr_word   = {addr_q, 8'h01, cmd_q, 7'h00};
    assign rd_timeout = (timer_q == TMR_LAST);
    // GAP always lasts at least one cycle; with GAP_CYCLES=0 the counter is
    // already at GAP_LAST on entry, so it falls straight through.
    assign gap_done   = (gap_cnt_q == GAP_LAST);
    assign busy       = (state_q != S_IDLE);
    assign fsm_state  = state_q;

    // Unpack the flat per-requester address/data buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[16*i +: 16];
            data_arr[i] = req_data[32*i +: 32];
        end
    end

    // Round-robin pick: first pending requester at or after ptr_q, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_cand  = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(arb_cand);
            if (!gnt_found && req_vld[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_100m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the frame port and acknowledge outputs.
    always_comb begin
        state_d            = state_q;
        pmt_master_wr_data = 32'h0;
        pmt_master_wr_vld  = 2'b00;
        req_ack            = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                pmt_master_wr_data = hdr_word;
                pmt_master_wr_vld  = 2'b11;
                if (pmt_master_wr_rdy) begin
                    state_d = S_DAT;
                end
            end
            S_DAT: begin
                pmt_master_wr_data = data_q;
                pmt_master_wr_vld  = 2'b01;
                if (pmt_master_wr_rdy) begin
                    req_ack[idx_q] = 1'b1;
                    state_d        = cmd_q ? S_WAIT_RSP : S_GAP;
                end
            end
            S_WAIT_RSP: begin
                if (pmt_master_rd_vld || rd_timeout) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant latch and round-robin pointer; fields are frozen for the whole frame.
    always_ff @(posedge clk_100m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q  <= '0;
            idx_q  <= '0;
            cmd_q  <= 1'b0;
            addr_q <= 16'h0;
            data_q <= 32'h0;
        end else if (state_q == S_IDLE && gnt_found) begin
            idx_q  <= gnt_idx;
            cmd_q  <= req_cmd[gnt_idx];
            addr_q <= addr_arr[gnt_idx];
            data_q <= data_arr[gnt_idx];
            ptr_q  <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Read-back timer (cleared while the data word is offered) and gap counter.
    always_ff @(posedge clk_100m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer_q   <= '0;
            gap_cnt_q <= 8'h0;
        end else begin
            if (state_q == S_WAIT_RSP) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
            if (state_q == S_GAP) begin
                gap_cnt_q <= gap_cnt_q + 8'h1;
            end else begin
                gap_cnt_q <= 8'h0;
            end
        end
    end

    // Registered read response; a real read-back word wins over a same-cycle timeout.
    always_ff @(posedge clk_100m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_vld  <= '0;
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_vld <= '0;
            if (state_q == S_WAIT_RSP) begin
                if (pmt_master_rd_vld) begin
                    rsp_vld[idx_q] <= 1'b1;
                    rsp_data       <= pmt_master_rd_data;
                    rsp_err        <= 1'b0;
                end else if (rd_timeout) begin
                    rsp_vld[idx_q] <= 1'b1;
                    rsp_data       <= TIMEOUT_WORD;
                    rsp_err        <= 1'b1;
                end
            end
        end
    end

endmodule
